// File: rtl/rom_arb_pkg.sv
// Shared types and default sizes for the ROM fetch arbiter: sequencer states,
// port ownership and the width helper for the optional age counter.
package rom_arb_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // Bits needed to hold 0..limit.
  function automatic int age_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Bundle of the two requester ports, the ROM pins and the busy flag.
// The arbiter uses the slave view; requesters and ROM model use master.
interface rom_fetch_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  a_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  busy;

  modport slave (
    input  a_req, a_addr, b_req, b_addr, mem_q,
    output a_ack, a_rdata, b_ack, b_rdata, mem_addr, busy
  );

  modport master (
    output a_req, a_addr, b_req, b_addr, mem_q,
    input  a_ack, a_rdata, b_ack, b_rdata, mem_addr, busy
  );

endinterface

// File: rtl/rom_arb_age_counter.sv
// Saturating count of arbitrations port B lost while requesting; raises
// force_b once the count reaches STARVE_LIMIT so B takes the next grant.
module rom_arb_age_counter
  import rom_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_valid,
  input  logic b_req,
  input  logic b_grant,
  output logic force_b
);

  localparam int            CW    = age_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (b_grant) begin
      count <= '0;
    end else if (arb_valid && b_req && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign force_b = (count == LIMIT);

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one combinational-read ROM between CPU fetch (A, fixed priority)
// and debug readback (B). Optional B age guard: define ROM_ARB_AGE_GUARD_EN.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  rom_fetch_arbiter_if.slave  bus
);

  state_t                state_q,   state_d;
  owner_t                owner_q,   owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  a_ack_q,   a_ack_d;
  logic                  b_ack_q,   b_ack_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic arb_valid;
  logic b_wins;
  logic force_b;

  assign arb_valid = (state_q == ST_IDLE) && (bus.a_req || bus.b_req);
  assign b_wins    = bus.b_req && (!bus.a_req || force_b);

`ifdef ROM_ARB_AGE_GUARD_EN
  rom_arb_age_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_age_counter (
    .clk       (clk),
    .reset     (reset),
    .arb_valid (arb_valid),
    .b_req     (bus.b_req),
    .b_grant   (arb_valid && b_wins),
    .force_b   (force_b)
  );
`else
  // Fixed priority: B is never forced (a legal limit is at least 1).
  assign force_b = (STARVE_LIMIT == 0);
`endif

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = b_wins ? OWNER_B : OWNER_A;
          addr_d  = b_wins ? bus.b_addr : bus.a_addr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // ROM data is valid here; capture it so ack and rdata leave flops.
        if (owner_q == OWNER_A) begin
          a_rdata_d = bus.mem_q;
          a_ack_d   = 1'b1;
        end else begin
          b_rdata_d = bus.mem_q;
          b_ack_d   = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_A;
      addr_q    <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule
